spi_bus_scheduler: RTL and testbench
====================================

Name: spi_bus_scheduler

Overview:
- Round-robin SPI master that shares one 8-bit full-duplex SPI bus among NREQ local requesters.
- Each requester owns one slave chip-select.
- Grants one requester at a time, generates sclk from the system clock, and drives the per-slave active-low select with setup, hold and inter-frame gaps.
- Returns the received byte with a one-cycle done strobe; bus side is compatible with the team's Slave block.

Parameters:
- NREQ, 4, number of requesters and chip-selects (2..8)
- CLK_DIV, 4, clk cycles per sclk half-period (>=1)
- CS_SETUP, 2, clk cycles cs low before first sclk rise (>=1)
- CS_HOLD, 2, clk cycles cs held low after last sclk fall (>=1)
- GAP, 2, clk cycles cs high between frames, including the done cycle (>=1)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester transaction request, level
- tx_data  in  8*NREQ  byte to send; requester i at [8i+7:8i]
- grant  out  NREQ  one-hot, one-cycle pulse: request accepted, tx byte captured
- done  out  NREQ  one-hot, one-cycle pulse: frame complete, rx_data valid
- rx_data  out  8  last received byte; held until next done
- busy  out  1  high whenever state != IDLE
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data to slaves, MSB first
- miso  in  1  serial data from selected slave (tri-stated when no slave selected)
- cs  out  NREQ  active-low selects; cs[i] serves requester i

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). On reset, regardless of state:
  - outputs: cs=all ones, sclk=0, mosi=0, grant=0, done=0, rx_data=0, busy=0
  - internals: state=IDLE, rr pointer=NREQ-1 (requester 0 searched first)
  - an aborted frame produces no done.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE, req!=0 in cycle T:
  - winner = first set bit searching from (ptr+1) mod NREQ upward with wrap
  - at end of T: ptr<=winner, shift reg<=tx_data[winner], mosi<=tx[7], cs[winner]<=0, grant[winner]<=1, state<=SETUP
  - grant is high in cycle T+1 only.
- SETUP: CS_SETUP cycles, sclk=0, then SHIFT.
- SHIFT: 8 bits, 2*CLK_DIV cycles each; sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. For bit b=0..7:
  - the clk edge raising sclk sets mosi<=tx[7-b] (bit 0 unchanged)
  - the clk edge dropping sclk samples miso into rx[7-b]
  - after the 8th falling edge: state<=HOLD, sclk stays 0.
- HOLD: CS_HOLD cycles with cs low. At its end:
  - cs<=all ones, mosi<=0
  - rx_data<=received byte, done[winner]<=1
  - state<=GAP.
- GAP: GAP cycles counted from the done cycle, then IDLE.
- Latency (defaults): grant at T+1, first sclk rise at T+3+CLK_DIV, done at T+1+CS_SETUP+16*CLK_DIV+CS_HOLD = T+69, IDLE at T+71; back-to-back grant period 71 cycles.
- req and tx_data are ignored outside the IDLE decision cycle. Dropping req mid-frame does not abort it. req still high after done is a new request arbitrated fairly.
- Exactly one cs low at any time; cs never changes while sclk=1.
- Arbitration: NREQ=1 degenerates to fixed grant. Simultaneous requests resolve strictly by rotation, so no requester waits more than NREQ-1 frames.

Test Plan:
- Single frame: req=0001, tx0=0xA5, slave model returns 0x3C. Expect:
  - grant=0001 at T+1, cs[0] low T+1..T+68
  - mosi bit sequence 1,0,1,0,0,1,0,1 at sclk rises
  - done=0001 at T+69, rx_data=0x3C, busy low at T+71.
- Contention: req=1111 held. Expect:
  - grants in order 0001,0010,0100,1000,0001
  - each 71 cycles apart, never two cs low.
- Fairness after wrap: ptr=2, req=0101 -> next grant 0001 (wrap past 3). Then req=0101 still -> grant 0100.
- Reset mid-SHIFT: assert reset after 3 bits. Expect:
  - next cycle cs=1111, sclk=0, busy=0
  - no done pulse
  - req=0010 afterwards -> grant 0010 and a normal frame.
- Timing with CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, GAP=1: tx=0xFF, miso=0. Expect:
  - sclk period 2 clk, done at T+19, rx_data=0x00
  - next grant at T+21.
- Late req drop: req[1] deasserted the cycle after grant -> frame completes, done[1] asserted, no second grant.

Source files
------------

// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin SPI master sharing one 8-bit bus
// among NREQ requesters, each owning one active-low slave select.
module spi_bus_scheduler #(
  parameter int NREQ     = 4,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NREQ-1:0]   cs
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAPS
  } state_t;

  state_t          st, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bitn, bitn_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [7:0]      txs, txs_n;
  logic [7:0]      rxs, rxs_n;
  logic [7:0]      rxq_n;
  logic [NREQ-1:0] grant_n, done_n, cs_n;
  logic            sclk_n, mosi_n;
  logic [PW-1:0]   win, idx;
  logic            found;

  assign busy = (st != IDLE);

  // first requester above the last winner, wrapping around
  always_comb begin : arb
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin : fsm
    st_n    = st;
    cnt_n   = cnt;
    bitn_n  = bitn;
    ptr_n   = ptr;
    txs_n   = txs;
    rxs_n   = rxs;
    rxq_n   = rx_data;
    sclk_n  = sclk;
    mosi_n  = mosi;
    cs_n    = cs;
    grant_n = '0;
    done_n  = '0;
    unique case (st)
      IDLE: begin
        if (found) begin
          ptr_n   = win;
          txs_n   = tx_data[{win, 3'b000} +: 8];
          mosi_n  = txs_n[7];
          cs_n    = ~(NREQ'(1) << win);
          grant_n = NREQ'(1) << win;
          cnt_n   = '0;
          st_n    = SETUP;
        end
      end
      SETUP: begin
        if (cnt == CW'(CS_SETUP - 1)) begin
          cnt_n  = '0;
          bitn_n = '0;
          st_n   = SHIFT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (!sclk) begin
            sclk_n = 1'b1;
            // bit 7 is already on mosi from the grant cycle
            if (bitn != 3'd0) begin
              mosi_n = txs[6];
              txs_n  = {txs[6:0], 1'b0};
            end
          end else begin
            sclk_n = 1'b0;
            rxs_n  = {rxs[6:0], miso};
            if (bitn == 3'd7) begin
              st_n = HOLD;
            end else begin
              bitn_n = bitn + 3'd1;
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (cnt == CW'(CS_HOLD - 1)) begin
          cnt_n  = '0;
          cs_n   = '1;
          mosi_n = 1'b0;
          rxq_n  = rxs;
          done_n = NREQ'(1) << ptr;
          st_n   = GAPS;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAPS: begin
        if (cnt == CW'(GAP - 1)) begin
          cnt_n = '0;
          st_n  = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      cnt     <= '0;
      bitn    <= '0;
      ptr     <= PW'(NREQ - 1);
      txs     <= '0;
      rxs     <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= '1;
      grant   <= '0;
      done    <= '0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      bitn    <= bitn_n;
      ptr     <= ptr_n;
      txs     <= txs_n;
      rxs     <= rxs_n;
      rx_data <= rxq_n;
      sclk    <= sclk_n;
      mosi    <= mosi_n;
      cs      <= cs_n;
      grant   <= grant_n;
      done    <= done_n;
    end
  end
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: directed and random frames against a
// timing/arbitration reference model with an SPI slave model.
module tb_spi_bus_scheduler;
  localparam int N = 4;
  localparam int CD = 4;
  localparam int SU = 2;
  localparam int HD = 2;
  localparam int GP = 2;
  localparam int T_GRANT = 1;
  localparam int T_RISE1 = 1 + SU + CD;
  localparam int T_CSEND = SU + 16 * CD + HD;
  localparam int T_DONE = 1 + SU + 16 * CD + HD;
  localparam int T_IDLE = T_DONE + GP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] tx_data;
  logic [N-1:0]   grant, done, cs;
  logic [7:0]     rx_data;
  logic           busy, sclk, mosi;
  logic           miso = 1'b0;

  logic [N-1:0]   req2, grant2, done2, cs2;
  logic [8*N-1:0] tx2;
  logic [7:0]     rx2;
  logic           busy2, sclk2, mosi2, miso2;
  assign miso2 = 1'b0;

  spi_bus_scheduler dut (
    .clk(clk), .reset(reset), .req(req),
    .tx_data(tx_data), .grant(grant), .done(done),
    .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs(cs)
  );

  spi_bus_scheduler #(
    .NREQ(N), .CLK_DIV(1), .CS_SETUP(1),
    .CS_HOLD(1), .GAP(1)
  ) fast (
    .clk(clk), .reset(reset), .req(req2),
    .tx_data(tx2), .grant(grant2), .done(done2),
    .rx_data(rx2), .busy(busy2), .sclk(sclk2),
    .mosi(mosi2), .miso(miso2), .cs(cs2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor and slave model for the default instance
  int         gq_c[$];
  logic [N-1:0] gq_v[$];
  int         dq_c[$];
  logic [N-1:0] dq_v[$];
  logic [7:0] dq_r[$];
  logic [7:0] mbits = '0;
  logic [7:0] sbyte = '0;
  int         nrise = 0;
  int         rise1 = -1;
  int         cslo_a = -1;
  int         cslo_b = -1;
  int         viol = 0;
  logic       sclk_p = 1'b0;
  logic [N-1:0] cs_p = '1;

  always @(negedge clk) begin
    if (grant != '0) begin
      gq_c.push_back(cyc);
      gq_v.push_back(grant);
    end
    if (done != '0) begin
      dq_c.push_back(cyc);
      dq_v.push_back(done);
      dq_r.push_back(rx_data);
    end
    if ($countones(~cs) > 1) viol++;
    if (cs != cs_p && (sclk || sclk_p)) viol++;
    if (cs != '1) begin
      if (cs_p == '1) cslo_a = cyc;
      cslo_b = cyc;
    end
    if (sclk && !sclk_p) begin
      if (nrise == 0) rise1 = cyc;
      if (nrise < 8) begin
        mbits[3'(7 - nrise)] = mosi;
        miso = sbyte[3'(7 - nrise)];
      end
      nrise++;
    end
    if (cs == '1) nrise = 0;
    sclk_p = sclk;
    cs_p = cs;
  end

  int         g2_c[$];
  int         d2_c[$];
  logic [7:0] d2_r[$];
  int         r2_c[$];
  logic       sclk2_p = 1'b0;

  always @(negedge clk) begin
    if (grant2 != '0) g2_c.push_back(cyc);
    if (done2 != '0) begin
      d2_c.push_back(cyc);
      d2_r.push_back(rx2);
    end
    if (sclk2 && !sclk2_p) r2_c.push_back(cyc);
    sclk2_p = sclk2;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // reference arbiter: rotation pointer, search upward with wrap
  int mptr;
  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic frame(input logic [N-1:0] r, input logic [7:0] sb,
                       input bit drop, input bit keep,
                       output logic [N-1:0] g, output int gc);
    int t, gi, di, w, vi;
    logic [7:0] txw;
    g = '0;
    gc = -1;
    for (int i = 0; i < 300 && busy; i++) step();
    gi = gq_c.size();
    di = dq_c.size();
    vi = viol;
    sbyte = sb;
    t = cyc;
    req = r;
    w = pick(mptr, r);
    mptr = w;
    txw = tx_data[8*w +: 8];
    for (int i = 0; i < 200 && dq_c.size() == di; i++) begin
      step();
      if (drop && gq_c.size() > gi) req = '0;
    end
    for (int i = 0; i < 20 && busy; i++) step();
    if (!keep) req = '0;
    chk("busy_low_cyc", cyc, t + T_IDLE);
    chk("grant_count", gq_c.size() - gi, 1);
    if (gq_c.size() > gi) begin
      g = gq_v[gi];
      gc = gq_c[gi];
      chk("grant_val", g, N'(1) << w);
      chk("grant_cyc", gc, t + T_GRANT);
    end
    chk("done_count", dq_c.size() - di, 1);
    if (dq_c.size() > di) begin
      chk("done_val", dq_v[di], N'(1) << w);
      chk("done_cyc", dq_c[di], t + T_DONE);
      chk("rx_data", dq_r[di], sb);
    end
    chk("mosi_bits", mbits, txw);
    chk("first_rise", rise1, t + T_RISE1);
    chk("cs_low_first", cslo_a, t + 1);
    chk("cs_low_last", cslo_b, t + T_CSEND);
    chk("cs_rules", viol, vi);
  endtask

  logic [N-1:0] g;
  int gc, prev, t, di, n;
  logic [N-1:0] order [5];

  initial begin
    reset = 1'b1;
    req = '0;
    req2 = '0;
    tx_data = '0;
    tx2 = '0;
    mptr = N - 1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_cs", cs, 4'b1111);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_busy", busy, 0);

    // fast timing: CLK_DIV=1, setup/hold/gap of 1
    tx2 = {24'h0, 8'hFF};
    t = cyc;
    req2 = 4'b0001;
    for (int i = 0; i < 60 && g2_c.size() < 2; i++) step();
    req2 = '0;
    chk("fast_grants", g2_c.size(), 2);
    chk("fast_dones", d2_c.size(), 1);
    if (g2_c.size() >= 2) begin
      chk("fast_grant1", g2_c[0], t + 1);
      chk("fast_grant2", g2_c[1], t + 21);
    end
    if (d2_c.size() >= 1) begin
      chk("fast_done_cyc", d2_c[0], t + 19);
      chk("fast_rx", d2_r[0], 0);
    end
    if (r2_c.size() >= 2) chk("fast_sclk_per", r2_c[1] - r2_c[0], 2);

    // contention: all requesting, strict rotation 71 cycles apart
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    tx_data = $urandom();
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      frame(4'b1111, 8'($urandom()), 0, i < 4, g, gc);
      chk("rr_order", g, order[i]);
      if (prev >= 0) chk("rr_spacing", gc - prev, 71);
      prev = gc;
    end

    // single frame
    tx_data = {24'h0, 8'hA5};
    frame(4'b0001, 8'h3C, 0, 0, g, gc);
    chk("single_grant", g, 4'b0001);
    chk("single_mosi", mbits, 8'hA5);

    // fairness after wrap
    tx_data = $urandom();
    frame(4'b0100, 8'($urandom()), 0, 0, g, gc);
    frame(4'b0101, 8'($urandom()), 0, 1, g, gc);
    chk("wrap_grant", g, 4'b0001);
    frame(4'b0101, 8'($urandom()), 0, 0, g, gc);
    chk("wrap_grant2", g, 4'b0100);

    // late request drop still completes, no regrant
    frame(4'b0010, 8'($urandom()), 1, 0, g, gc);
    chk("drop_grant", g, 4'b0010);
    n = gq_c.size();
    repeat (80) step();
    chk("drop_no_regrant", gq_c.size(), n);

    // reset during the fourth bit aborts silently
    tx_data = $urandom();
    sbyte = 8'h5A;
    di = dq_c.size();
    req = 4'b0001;
    step();
    req = '0;
    repeat (28) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mptr = N - 1;
    chk("abort_cs", cs, 4'b1111);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    repeat (80) step();
    chk("abort_no_done", dq_c.size(), di);
    frame(4'b0010, 8'($urandom()), 0, 0, g, gc);
    chk("post_rst_grant", g, 4'b0010);

    // random traffic
    for (int i = 0; i < 6; i++) begin
      tx_data = $urandom();
      frame(4'($urandom_range(1, 15)), 8'($urandom()), 0, 0, g, gc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
